// File: rtl/can_tx_scheduler_pkg.sv
// ============================================================================
// can_pkg : shared constants, state encoding and frame layout for the CAN TX
// scheduler.                                                    Rev 1.0
// ============================================================================
`default_nettype none

package can_pkg;

  localparam int CAN_FRAME_W  = 66;
  localparam int CAN_CRC_BITS = 51;
  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;
  localparam logic [3:0]  CAN_DLC      = 4'b0100;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_CTRL_W = 6;
  localparam int CAN_DATA_W = 32;
  localparam int CAN_CRC_W  = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CRC       = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } can_tx_state_t;

  // Field order matches transmission order, MSB first.
  typedef struct packed {
    logic                  sof;
    logic [CAN_ID_W-1:0]   id;
    logic                  rtr;
    logic [CAN_CTRL_W-1:0] ctrl;
    logic [CAN_DATA_W-1:0] data;
    logic [CAN_CRC_W-1:0]  crc;
  } can_frame_t;

  // IDE = 0, r0 = 0, then the fixed data length code.
  function automatic logic [CAN_CTRL_W-1:0] can_ctrl_field();
    return {1'b0, 1'b0, CAN_DLC};
  endfunction

endpackage

`default_nettype wire

// File: rtl/can_tx_scheduler_crc15.sv
// ============================================================================
// can_crc15 : serial CAN CRC-15, one bit per enabled cycle.     Rev 1.0
// ============================================================================
`default_nettype none

module can_crc15
  import can_pkg::*;
(
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [CAN_CRC_W-1:0] crc_out
);

  logic [CAN_CRC_W-1:0] crc_q;
  logic [CAN_CRC_W-1:0] crc_d;
  logic [CAN_CRC_W-1:0] step;
  logic                 nxt;

  always_comb begin
    nxt   = bit_in ^ crc_q[CAN_CRC_W-1];
    step  = {crc_q[CAN_CRC_W-2:0], 1'b0} ^ (nxt ? CAN_CRC_POLY : '0);
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = step;
    end
  end

  // Look-ahead: while enabled, the output already includes the current bit,
  // so the caller can capture the final CRC on the same edge as the last bit.
  assign crc_out = enable ? step : crc_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/can_tx_scheduler.sv
// ============================================================================
// can_tx_scheduler : arbitrates CAN TX mailboxes, builds the unstuffed frame
// and sequences the bit stuffer. Optional macro CAN_TX_FRAME_CNT_EN adds
// frame_count_o.                                                Rev 1.0
// ============================================================================
`default_nettype none

module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int NUM_MB     = 4,
  parameter int IFS_CYCLES = 3
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [NUM_MB-1:0]            req_i,
  input  logic [NUM_MB*CAN_ID_W-1:0]   id_i,
  input  logic [NUM_MB-1:0]            rtr_i,
  input  logic [NUM_MB*CAN_DATA_W-1:0] data_i,
  output logic [NUM_MB-1:0]            grant_o,
  output logic [NUM_MB-1:0]            sent_o,
  output logic                         busy_o,
  output logic [CAN_FRAME_W-1:0]       unstuffed_o,
  output logic                         stuffer_start_o,
`ifdef CAN_TX_FRAME_CNT_EN
  output logic [15:0]                  frame_count_o,
`endif
  input  logic                         stuffer_done_i
);

  localparam int IDX_W = (NUM_MB > 1) ? $clog2(NUM_MB) : 1;
  localparam int CNT_W = 16;

  function automatic logic [NUM_MB-1:0] mb_onehot(input logic [IDX_W-1:0] idx);
    mb_onehot      = '0;
    mb_onehot[idx] = 1'b1;
  endfunction

  can_tx_state_t         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      win_q, win_d;
  logic [CAN_ID_W-1:0]   id_q, id_d;
  logic                  rtr_q, rtr_d;
  logic [CAN_DATA_W-1:0] data_q, data_d;
  logic [NUM_MB-1:0]     grant_q, grant_d;
  logic [NUM_MB-1:0]     sent_q, sent_d;
  logic                  busy_q, busy_d;
  logic [CAN_FRAME_W-1:0] unstuffed_q, unstuffed_d;
  logic                  start_q, start_d;

  logic                  arb_found;
  logic [IDX_W-1:0]      arb_idx;
  logic [CAN_ID_W-1:0]   arb_id;
  logic                  arb_rtr;
  logic [CAN_DATA_W-1:0] arb_data;

  logic [CAN_CRC_BITS-1:0] hdr;
  logic [5:0]              bit_idx;
  logic                    crc_bit;
  logic                    crc_clear;
  logic                    crc_en;
  logic [CAN_CRC_W-1:0]    crc_val;
  can_frame_t              frame;

  // Strict less-than keeps the lowest index on equal identifiers.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_id    = '0;
    arb_rtr   = 1'b0;
    arb_data  = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (req_i[i] && (!arb_found || (id_i[i*CAN_ID_W +: CAN_ID_W] < arb_id))) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(i);
        arb_id    = id_i[i*CAN_ID_W +: CAN_ID_W];
        arb_rtr   = rtr_i[i];
        arb_data  = data_i[i*CAN_DATA_W +: CAN_DATA_W];
      end
    end
  end

  always_comb begin
    hdr     = {1'b0, id_q, rtr_q, can_ctrl_field(), data_q};
    bit_idx = 6'(CAN_CRC_BITS - 1) - cnt_q[5:0];
    crc_bit = hdr[bit_idx];
  end

  can_crc15 u_crc (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear   (crc_clear),
    .enable  (crc_en),
    .bit_in  (crc_bit),
    .crc_out (crc_val)
  );

  always_comb begin
    frame.sof  = 1'b0;
    frame.id   = id_q;
    frame.rtr  = rtr_q;
    frame.ctrl = can_ctrl_field();
    frame.data = data_q;
    frame.crc  = crc_val;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    id_d        = id_q;
    rtr_d       = rtr_q;
    data_d      = data_q;
    grant_d     = '0;
    sent_d      = '0;
    start_d     = 1'b0;
    unstuffed_d = unstuffed_q;
    crc_clear   = 1'b0;
    crc_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        crc_clear   = 1'b1;
        unstuffed_d = '0;
        if (arb_found) begin
          win_d   = arb_idx;
          id_d    = arb_id;
          rtr_d   = arb_rtr;
          data_d  = arb_rtr ? '0 : arb_data;
          grant_d = mb_onehot(arb_idx);
          cnt_d   = '0;
          state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        crc_en = 1'b1;
        if (cnt_q == CNT_W'(CAN_CRC_BITS - 1)) begin
          unstuffed_d = frame;
          start_d     = 1'b1;
          cnt_d       = '0;
          state_d     = ST_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // The first cycle here masks any done left over from before the start.
        if (cnt_q == '0) begin
          cnt_d = CNT_W'(1);
        end else if (stuffer_done_i) begin
          sent_d      = mb_onehot(win_q);
          unstuffed_d = '0;
          cnt_d       = '0;
          state_d     = (IFS_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(IFS_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      win_q       <= '0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      data_q      <= '0;
      grant_q     <= '0;
      sent_q      <= '0;
      busy_q      <= 1'b0;
      unstuffed_q <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      sent_q      <= sent_d;
      busy_q      <= busy_d;
      unstuffed_q <= unstuffed_d;
      start_q     <= start_d;
    end
  end

  assign grant_o         = grant_q;
  assign sent_o          = sent_q;
  assign busy_o          = busy_q;
  assign unstuffed_o     = unstuffed_q;
  assign stuffer_start_o = start_q;

`ifdef CAN_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (|sent_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count_o = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_can_tx_scheduler.sv
// ============================================================================
// tb_can_tx_scheduler : scoreboard bench for can_tx_scheduler with a
// behavioural frame/CRC model and a stuffer model.              Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_can_tx_scheduler;
  import can_pkg::*;

  localparam int NUM_MB   = 4;
  localparam int IFS      = 3;
  localparam int DONE_DLY = 80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NUM_MB-1:0] req = '0;
  logic [NUM_MB-1:0] rtr = '0;
  logic [NUM_MB-1:0] hold = '0;
  logic [10:0] mb_id [NUM_MB];
  logic [31:0] mb_data [NUM_MB];
  logic [NUM_MB*11-1:0] id_flat;
  logic [NUM_MB*32-1:0] data_flat;
  logic done = 1'b0;
  logic stale_req = 1'b0;

  always_comb begin
    id_flat   = '0;
    data_flat = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      id_flat[i*11 +: 11]   = mb_id[i];
      data_flat[i*32 +: 32] = mb_data[i];
    end
  end

  logic [NUM_MB-1:0] grant_o, sent_o;
  logic              busy_o, stuffer_start_o;
  logic [65:0]       unstuffed_o;
`ifdef CAN_TX_FRAME_CNT_EN
  logic [15:0]       frame_count_o;
`endif

  can_tx_scheduler #(.NUM_MB(NUM_MB), .IFS_CYCLES(IFS)) dut (
    .clock_i         (clk),
    .reset_i         (rst_n),
    .req_i           (req),
    .id_i            (id_flat),
    .rtr_i           (rtr),
    .data_i          (data_flat),
    .grant_o         (grant_o),
    .sent_o          (sent_o),
    .busy_o          (busy_o),
    .unstuffed_o     (unstuffed_o),
    .stuffer_start_o (stuffer_start_o),
`ifdef CAN_TX_FRAME_CNT_EN
    .frame_count_o   (frame_count_o),
`endif
    .stuffer_done_i  (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input bit ok, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference frame: header fields concatenated, CRC computed bit by bit.
  function automatic logic [65:0] model_frame(input logic [10:0] id, input logic r, input logic [31:0] d);
    logic [50:0] hdr;
    logic [14:0] crc;
    logic        nx;
    hdr = {1'b0, id, r, 6'b000100, (r ? 32'h0 : d)};
    crc = '0;
    for (int b = 50; b >= 0; b--) begin
      nx  = hdr[b] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (nx ? 15'h4599 : 15'h0);
    end
    return {hdr, crc};
  endfunction

  typedef struct {
    int          mb;
    logic [65:0] frame;
  } exp_t;
  exp_t sb[$];

  // Expected service order: repeatedly take the requester with smallest (id, index).
  task automatic push_order(input logic [NUM_MB-1:0] mask);
    logic [NUM_MB-1:0] m;
    int best;
    m = mask;
    while (m != '0) begin
      best = -1;
      for (int i = 0; i < NUM_MB; i++)
        if (m[i] && (best < 0 || mb_id[i] < mb_id[best])) best = i;
      sb.push_back('{best, model_frame(mb_id[best], rtr[best], mb_data[best])});
      m[best] = 1'b0;
    end
  endtask

  // Advance to the next falling edge; a granted mailbox then drops req and scrambles its inputs.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NUM_MB; i++) begin
      if (grant_o[i] && !hold[i]) begin
        req[i]     = 1'b0;
        mb_id[i]   = 11'($urandom);
        mb_data[i] = $urandom;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy_o) && n < 6000) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 6000, 66'(n), 66'(6000));
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (grant_o == '0 && n < 500) begin
      tick();
      n++;
    end
    check("grant_wait", grant_o != '0, 66'(n), 66'(500));
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!stuffer_start_o && n < 500) begin
      tick();
      n++;
    end
    check("start_wait", stuffer_start_o, 66'(n), 66'(500));
  endtask

  // Stuffer model: done pulses DONE_DLY cycles after start; optionally a stale
  // done is held across the start and the first wait cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (grant_o != '0 && stale_req) done = 1'b1;
      if (stuffer_start_o && rst_n) begin
        for (int k = 1; k <= DONE_DLY; k++) begin
          @(negedge clk);
          if (k == 2 && stale_req) done = 1'b0;
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
      end
    end
  end

  // Monitor
  bit granted = 0, started = 0, have_sent = 0, pend_at_sent = 0;
  int grant_cyc = 0, start_cyc = 0, last_sent = 0, fc_exp = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      granted   = 0;
      started   = 0;
      have_sent = 0;
      fc_exp    = 0;
    end else begin
      if (grant_o != '0) begin
        if (sb.size() == 0) begin
          check("grant_unexpected", 1'b0, 66'(grant_o), 66'(0));
        end else begin
          check("grant_mb", grant_o == NUM_MB'(1 << sb[0].mb), 66'(grant_o), 66'(1 << sb[0].mb));
          if (have_sent) begin
            if (pend_at_sent)
              check("gap_exact", cyc == last_sent + IFS + 1, 66'(cyc - last_sent), 66'(IFS + 1));
            else
              check("gap_min", cyc - last_sent >= IFS + 1, 66'(cyc - last_sent), 66'(IFS + 1));
          end
          granted   = 1;
          started   = 0;
          grant_cyc = cyc;
        end
      end
      if (stuffer_start_o) begin
        if (!granted || sb.size() == 0) begin
          check("start_unexpected", 1'b0, 66'(1), 66'(0));
        end else begin
          check("start_latency", cyc == grant_cyc + 51, 66'(cyc - grant_cyc), 66'(51));
          check("frame", unstuffed_o == sb[0].frame, unstuffed_o, sb[0].frame);
          started   = 1;
          start_cyc = cyc;
        end
      end
      if (sent_o != '0) begin
        if (!started || sb.size() == 0) begin
          check("sent_unexpected", 1'b0, 66'(sent_o), 66'(0));
        end else begin
          check("sent_mb", sent_o == NUM_MB'(1 << sb[0].mb), 66'(sent_o), 66'(1 << sb[0].mb));
          check("sent_latency", cyc == start_cyc + DONE_DLY + 1, 66'(cyc - start_cyc), 66'(DONE_DLY + 1));
          check("unstuffed_cleared", unstuffed_o == '0, unstuffed_o, 66'(0));
          fc_exp++;
`ifdef CAN_TX_FRAME_CNT_EN
          check("frame_count", frame_count_o == 16'(fc_exp), 66'(frame_count_o), 66'(16'(fc_exp)));
`endif
          void'(sb.pop_front());
          granted      = 0;
          started      = 0;
          have_sent    = 1;
          last_sent    = cyc;
          pend_at_sent = (req != '0);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"},     grant_o == '0,         66'(grant_o),         66'(0));
    check({tag, "_sent"},      sent_o == '0,          66'(sent_o),          66'(0));
    check({tag, "_busy"},      busy_o == 1'b0,        66'(busy_o),          66'(0));
    check({tag, "_start"},     stuffer_start_o == 0,  66'(stuffer_start_o), 66'(0));
    check({tag, "_unstuffed"}, unstuffed_o == '0,     unstuffed_o,          66'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected < 100000", cyc);
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    for (int i = 0; i < NUM_MB; i++) begin
      mb_id[i]   = '0;
      mb_data[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    #1;
    check_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request with a fixed grant latency check
    mb_id[0] = 11'h123; rtr[0] = 1'b0; mb_data[0] = 32'hDEADBEEF;
    push_order(4'b0001);
    req[0] = 1'b1;
    @(posedge clk);
    #1;
    check("grant_latency", grant_o == 4'b0001, 66'(grant_o), 66'(4'b0001));
    drain();

    // Priority: lower id wins regardless of index
    mb_id[1] = 11'h100; mb_data[1] = $urandom; rtr[1] = 1'b0;
    mb_id[2] = 11'h0FF; mb_data[2] = $urandom; rtr[2] = 1'b0;
    push_order(4'b0110);
    tick();
    req = 4'b0110;
    drain();

    // Tie: lowest index first
    mb_id[0] = 11'h055; mb_data[0] = $urandom; rtr[0] = 1'b0;
    mb_id[3] = 11'h055; mb_data[3] = $urandom; rtr[3] = 1'b0;
    push_order(4'b1001);
    tick();
    req = 4'b1001;
    drain();

    // Request while busy, with a stale done held across START
    mb_id[0] = 11'h300; mb_data[0] = $urandom; rtr[0] = 1'b0;
    push_order(4'b0001);
    stale_req = 1'b1;
    tick();
    req[0] = 1'b1;
    wait_grant();
    wait_start();
    repeat (3) tick();
    mb_id[1] = 11'h001; mb_data[1] = $urandom; rtr[1] = 1'b0;
    push_order(4'b0010);
    req[1] = 1'b1;
    drain();
    stale_req = 1'b0;

    // Reset 20 cycles into CRC; frame must be retried intact
    mb_id[0] = 11'h2A1; mb_data[0] = $urandom; rtr[0] = 1'b0;
    hold[0] = 1'b1;
    push_order(4'b0001);
    tick();
    req[0] = 1'b1;
    wait_grant();
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    hold[0] = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    drain();

    // Remote frame: data field transmitted as zero
    mb_id[2] = 11'h7FF; rtr[2] = 1'b1; mb_data[2] = 32'h12345678;
    push_order(4'b0100);
    tick();
    req[2] = 1'b1;
    wait_start();
    check("rtr_data_zero", unstuffed_o[46:15] == 32'h0, 66'(unstuffed_o[46:15]), 66'(0));
    drain();
    rtr = '0;

    // Randomised rounds; small id range makes ties likely
    for (int r = 0; r < 8; r++) begin
      logic [NUM_MB-1:0] mask;
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id[i]   = 11'($urandom_range(0, 15));
        rtr[i]     = ($urandom_range(0, 3) == 0);
        mb_data[i] = $urandom;
      end
      mask = NUM_MB'($urandom_range(1, (1 << NUM_MB) - 1));
      push_order(mask);
      repeat ($urandom_range(1, 5)) tick();
      req = mask;
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
